// File: rtl/mandel_iter_ctrl.sv
// mandel_iter_ctrl
//   Sequencer for one Mandelbrot iteration engine. It takes one pixel job
//   (c, id, max_iter) at a time, pulses the datapath init, then walks the
//   per-stage register enables one-hot once per iteration. After each
//   iteration it samples the escape flag, and it retires
//   (id, iteration count, escaped) on a valid/ready result port.
//
// Optional build macro: MANDEL_PAUSE_EN adds the 'pause' input. While pause
//   is high, INIT/STEP/EVAL progress freezes and dp_init/stage_en are
//   suppressed. The IDLE and DONE handshakes still complete.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   pause                (MANDEL_PAUSE_EN only) freeze sequencing
//   job_*                job input handshake and payload
//   dp_c_re, dp_c_im     held c to datapath
//   dp_init              one-cycle datapath z=0 load
//   stage_en             one-hot stage register enables
//   dp_escape            |z|^2>4 from datapath, sampled in EVAL
//   res_*                result handshake and payload
//   busy                 controller not idle
//
// state | meaning
// IDLE  | waiting for a job, job_ready=1
// INIT  | dp_init pulse, datapath loads z=0
// STEP  | one stage enable per cycle, stage_idx 0..PIPE_STAGES-1
// EVAL  | sample dp_escape, count the iteration, decide
// DONE  | result offered until res_ready

module mandel_iter_ctrl #(
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int PIPE_STAGES       = 3,
  parameter int ITER_WIDTH        = 16,
  parameter int ID_WIDTH          = 20
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef MANDEL_PAUSE_EN
  input  logic                         pause,
`endif
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [ENGINE_DATA_WIDTH-1:0] job_cr,
  input  logic [ENGINE_DATA_WIDTH-1:0] job_ci,
  input  logic [ID_WIDTH-1:0]          job_id,
  input  logic [ITER_WIDTH-1:0]        job_max_iter,
  output logic [ENGINE_DATA_WIDTH-1:0] dp_c_re,
  output logic [ENGINE_DATA_WIDTH-1:0] dp_c_im,
  output logic                         dp_init,
  output logic [PIPE_STAGES-1:0]       stage_en,
  input  logic                         dp_escape,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic [ITER_WIDTH-1:0]        res_iter,
  output logic                         res_escaped,
  output logic                         busy
);

  localparam int SW = $clog2(PIPE_STAGES);

  typedef enum logic [2:0] {IDLE, INIT, STEP, EVAL, DONE} state_t;

  state_t                       state, state_d;
  logic [SW-1:0]                stage_idx, stage_idx_d;
  logic [ITER_WIDTH-1:0]        iter, iter_d, iter_next;
  logic [ITER_WIDTH-1:0]        max_iter, max_iter_d;
  logic [ENGINE_DATA_WIDTH-1:0] c_re_d, c_im_d;
  logic [ID_WIDTH-1:0]          res_id_d;
  logic [ITER_WIDTH-1:0]        res_iter_d;
  logic                         res_escaped_d;
  logic                         hold;

`ifdef MANDEL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign iter_next = iter + ITER_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      stage_idx   <= '0;
      iter        <= '0;
      max_iter    <= '0;
      dp_c_re     <= '0;
      dp_c_im     <= '0;
      res_id      <= '0;
      res_iter    <= '0;
      res_escaped <= 1'b0;
    end else begin
      state       <= state_d;
      stage_idx   <= stage_idx_d;
      iter        <= iter_d;
      max_iter    <= max_iter_d;
      dp_c_re     <= c_re_d;
      dp_c_im     <= c_im_d;
      res_id      <= res_id_d;
      res_iter    <= res_iter_d;
      res_escaped <= res_escaped_d;
    end
  end

  always_comb begin
    state_d       = state;
    stage_idx_d   = stage_idx;
    iter_d        = iter;
    max_iter_d    = max_iter;
    c_re_d        = dp_c_re;
    c_im_d        = dp_c_im;
    res_id_d      = res_id;
    res_iter_d    = res_iter;
    res_escaped_d = res_escaped;
    unique case (state)
      IDLE: begin
        if (job_valid) begin
          c_re_d     = job_cr;
          c_im_d     = job_ci;
          res_id_d   = job_id;
          max_iter_d = job_max_iter;
          iter_d     = '0;
          if (job_max_iter == '0) begin
            // A zero-iteration job retires immediately without touching the datapath.
            res_iter_d    = '0;
            res_escaped_d = 1'b0;
            state_d       = DONE;
          end else begin
            state_d = INIT;
          end
        end
      end
      INIT: begin
        if (!hold) begin
          stage_idx_d = '0;
          state_d     = STEP;
        end
      end
      STEP: begin
        if (!hold) begin
          if (stage_idx == SW'(PIPE_STAGES - 1)) state_d = EVAL;
          else stage_idx_d = stage_idx + SW'(1);
        end
      end
      EVAL: begin
        if (!hold) begin
          // Escape wins over the limit when both land on the same iteration.
          if (dp_escape) begin
            res_iter_d    = iter_next;
            res_escaped_d = 1'b1;
            state_d       = DONE;
          end else if (iter_next == max_iter) begin
            res_iter_d    = max_iter;
            res_escaped_d = 1'b0;
            state_d       = DONE;
          end else begin
            iter_d      = iter_next;
            stage_idx_d = '0;
            state_d     = STEP;
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The strobes are decoded from the registered state. A paused cycle
  // suppresses them without advancing, so the pulse is deferred, not lost.
  assign job_ready = (state == IDLE) && !reset;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dp_init   = (state == INIT) && !hold;
  assign stage_en  = (state == STEP && !hold) ? (PIPE_STAGES'(1) << stage_idx) : '0;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
module tb_mandel_iter_ctrl;

  localparam int DW = 25;
  localparam int PS = 3;
  localparam int IW = 16;
  localparam int ID = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          pause;
  logic          job_valid;
  logic          job_ready;
  logic [DW-1:0] job_cr, job_ci;
  logic [ID-1:0] job_id;
  logic [IW-1:0] job_max_iter;
  logic [DW-1:0] dp_c_re, dp_c_im;
  logic          dp_init;
  logic [PS-1:0] stage_en;
  logic          dp_escape;
  logic          res_valid;
  logic          res_ready;
  logic [ID-1:0] res_id;
  logic [IW-1:0] res_iter;
  logic          res_escaped;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mandel_iter_ctrl #(
    .ENGINE_DATA_WIDTH(DW), .PIPE_STAGES(PS), .ITER_WIDTH(IW), .ID_WIDTH(ID)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef MANDEL_PAUSE_EN
    .pause(pause),
`endif
    .job_valid(job_valid), .job_ready(job_ready),
    .job_cr(job_cr), .job_ci(job_ci), .job_id(job_id), .job_max_iter(job_max_iter),
    .dp_c_re(dp_c_re), .dp_c_im(dp_c_im), .dp_init(dp_init), .stage_en(stage_en),
    .dp_escape(dp_escape), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_iter(res_iter), .res_escaped(res_escaped), .busy(busy)
  );

  typedef struct {
    logic [IW-1:0] max_iter;
    int            esc_eval;   // EVAL number where dp_escape is raised, 0 = never
    logic [IW-1:0] exp_iter;
    logic          exp_esc;
    int            exp_lat;    // cycles from accept to res_valid
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offers one job in the current (IDLE) cycle, follows it cycle by cycle
  // against the fixed INIT / STEP x PS / EVAL schedule, then drains the result.
  task automatic run_job(input int n, input logic [IW-1:0] maxi, input int esc,
                         input logic [IW-1:0] eiter, input logic eesc, input int elat,
                         input logic [ID-1:0] id, input logic [DW-1:0] cr,
                         input logic [DW-1:0] ci);
    int c, seen, k, bad_c;
    logic [PS-1:0] exp_en;
    logic exp_init;
    check($sformatf("job%0d_ready_before", n), job_ready, 1);
    job_valid    = 1'b1;
    job_max_iter = maxi;
    job_id       = id;
    job_cr       = cr;
    job_ci       = ci;
    tick();
    job_valid = 1'b0;
    job_cr    = '0;
    job_ci    = '0;
    job_id    = '0;
    check($sformatf("job%0d_c_re", n), dp_c_re, cr);
    check($sformatf("job%0d_c_im", n), dp_c_im, ci);
    c = 1;
    seen = -1;
    bad_c = -1;
    while (c <= 200) begin
      k = (c - 2) % (PS + 1);
      exp_en = '0;
      exp_init = 1'b0;
      if (c < elat && maxi != 0) begin
        if (c == 1) exp_init = 1'b1;
        else if (k < PS) exp_en = PS'(1) << k;
      end
      // Raise escape on the chosen EVAL; also raise it mid-STEP as noise that must be ignored.
      dp_escape = (c >= 2 && esc != 0 && ((k == PS && (c - 2) / (PS + 1) + 1 == esc) || k == 1));
      if ((stage_en !== exp_en || dp_init !== exp_init || res_valid !== (c == elat)) && bad_c < 0)
        bad_c = c;
      if (res_valid) begin
        seen = c;
        break;
      end
      tick();
      c++;
    end
    dp_escape = 1'b0;
    check($sformatf("job%0d_latency", n), seen, elat);
    check($sformatf("job%0d_strobe_first_bad_cycle", n), bad_c, -1);
    check($sformatf("job%0d_res_iter", n), res_iter, eiter);
    check($sformatf("job%0d_res_escaped", n), res_escaped, eesc);
    check($sformatf("job%0d_res_id", n), res_id, id);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check($sformatf("job%0d_idle_after", n), {job_ready, busy, res_valid}, 3'b100);
  endtask

  initial begin
    int c;
    vecs[0] = '{max_iter: 10, esc_eval: 0, exp_iter: 10, exp_esc: 1'b0, exp_lat: 42};
    vecs[1] = '{max_iter: 10, esc_eval: 3, exp_iter: 3,  exp_esc: 1'b1, exp_lat: 14};
    vecs[2] = '{max_iter: 0,  esc_eval: 0, exp_iter: 0,  exp_esc: 1'b0, exp_lat: 1};
    vecs[3] = '{max_iter: 1,  esc_eval: 1, exp_iter: 1,  exp_esc: 1'b1, exp_lat: 6};
    vecs[4] = '{max_iter: 1,  esc_eval: 0, exp_iter: 1,  exp_esc: 1'b0, exp_lat: 6};
    vecs[5] = '{max_iter: 5,  esc_eval: 5, exp_iter: 5,  exp_esc: 1'b1, exp_lat: 22};
    vecs[6] = '{max_iter: 2,  esc_eval: 0, exp_iter: 2,  exp_esc: 1'b0, exp_lat: 10};

    reset = 1'b1; pause = 1'b0; job_valid = 1'b0; res_ready = 1'b0; dp_escape = 1'b0;
    job_cr = '0; job_ci = '0; job_id = '0; job_max_iter = '0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset%0d_outputs", i),
            {dp_c_re, dp_c_im, res_id, res_iter, res_escaped, res_valid, dp_init, stage_en, job_ready, busy},
            '0);
    end
    reset = 1'b0;
    #1;
    check("post_reset_ready_busy", {job_ready, busy}, 2'b10);

    for (int i = 0; i < 7; i++)
      run_job(i, vecs[i].max_iter, vecs[i].esc_eval, vecs[i].exp_iter, vecs[i].exp_esc,
              vecs[i].exp_lat, ID'(20'h1000 + i), DW'(25'h0ABC00 + i), DW'(25'h1F0000 - i));

    // Result back-pressure: a second offered job is ignored until the result drains.
    job_valid = 1'b1; job_max_iter = 1; job_id = 20'hAAAAA; job_cr = 25'h123456; job_ci = 25'h0654321;
    tick();
    job_id = 20'h55555; job_cr = 25'h1111111; job_ci = 25'h0222222;
    c = 1;
    while (!res_valid && c < 50) begin
      tick();
      c++;
    end
    check("bp_latency", c, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {res_valid, job_ready, res_id, res_iter, res_escaped},
            {1'b1, 1'b0, 20'hAAAAA, 16'd1, 1'b0});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_idle_ready", {job_ready, busy}, 2'b10);
    tick();
    job_valid = 1'b0;
    check("bp_second_accepted", {dp_init, busy, dp_c_re}, {1'b1, 1'b1, 25'h1111111});
    c = 1;
    while (!res_valid && c < 50) begin
      tick();
      c++;
    end
    check("bp_second_result", {c, res_id}, {32'd6, 20'h55555});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset in the middle of STEP drops the job.
    job_valid = 1'b1; job_max_iter = 4; job_id = 20'h00777; job_cr = 25'h7; job_ci = 25'h9;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    check("rst_mid_step_en", stage_en, 3'b010);
    reset = 1'b1;
    tick();
    check("rst_mid_step_after", {stage_en, res_valid, busy, dp_c_re, res_id, job_ready}, '0);
    reset = 1'b0;
    tick();
    check("rst_mid_step_idle", {job_ready, busy, res_valid}, 3'b100);

`ifdef MANDEL_PAUSE_EN
    // Pause four cycles mid-STEP: the stage is deferred and completion slips by four.
    job_valid = 1'b1; job_max_iter = 2; job_id = 20'h00321;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    check("pause_pre_en", stage_en, 3'b010);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("pause%0d_en", i), {stage_en, dp_init}, 4'b0000);
      tick();
    end
    pause = 1'b0;
    #1;
    check("pause_resume_en", stage_en, 3'b010);
    c = 7;
    while (!res_valid && c < 60) begin
      tick();
      c++;
    end
    check("pause_latency", c, 14);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
